tap_controller: RTL and testbench
=================================

// Module: tap_controller
// PURPOSE
//  IEEE 1149.1 TAP state machine. Sequences the instruction register and the data registers from TMS.
//  Emits capture/shift/update strobes and the active-low test-logic reset (tl_reset) consumed by the IR.
//  Also emits gated IR/DR shift clocks, the IR/DR TDO select and the TDO output enable.
//  Sits between the chip TAP pins and all JTAG registers; one instance per TAP.
// PARAMETERS
//  none; state encoding comes from jtag_pkg.
// PORTS
//  tck         in   1  TAP clock; the only clock. Both edges used.
//  reset       in   1  asynchronous, active-high reset (TRST-equivalent); forces TEST_LOGIC_RESET
//  tms         in   1  test mode select, sampled on posedge tck
//  tl_reset    out  1  active-low test-logic reset to IR/DRs
//  captureIR   out  1  high while state==CAPTURE_IR (combinational from state)
//  shiftIR     out  1  high while state==SHIFT_IR
//  updateIR    out  1  rising edge on the falling tck edge inside UPDATE_IR
//  captureDR   out  1  high while state==CAPTURE_DR
//  shiftDR     out  1  high while state==SHIFT_DR
//  updateDR    out  1  rising edge on the falling tck edge inside UPDATE_DR
//  tck_ir      out  1  gated tck; pulses only in CAPTURE_IR / SHIFT_IR
//  tck_dr      out  1  gated tck; pulses only in CAPTURE_DR / SHIFT_DR
//  select      out  1  1 = IR drives TDO, 0 = DR; high in SELECT_IR_SCAN..UPDATE_IR
//  tdo_en      out  1  TDO pad output enable
// BEHAVIOUR
//  - State register: updated on posedge tck. Standard 16-state 1149.1 graph, next state a function of (state, tms).
//  - Encodings (jtag_pkg::tap_state_t):
//    TLR=F RTI=C SELDR=7 CAPDR=6 SHDR=2 EX1DR=1 PAUDR=3 EX2DR=0 UPDDR=5
//    SELIR=4 CAPIR=E SHIR=A EX1IR=9 PAUIR=B EX2IR=8 UPDIR=D
//  - Key transitions:
//    TLR: tms=0 -> RTI. SELIR: tms=1 -> TLR.
//    EX1x / EX2x: tms=1 -> UPDx. PAUx: tms=0 -> hold.
//    UPDx: tms=1 -> SELDR, tms=0 -> RTI.
//  - Five consecutive tms=1 edges reach TLR from any state; TLR holds while tms=1.
//  - Negedge register group, updated on negedge tck from the current state:
//    tl_reset = (state!=TLR); updateIR = (state==UPDIR); updateDR = (state==UPDDR);
//    tdo_en = (state==SHIR || state==SHDR).
//    These change half a cycle after the posedge state update.
//  - updateIR/updateDR are high for exactly one tck period, falling edge to falling edge.
//  - capture/shift strobes: combinational decode of state, stable at the posedge that consumes them.
//  - Gated clocks use a latch-based ICG: enable latched while tck low, output = tck & en_q. No glitches, no partial pulses.
//  - reset=1 (async):
//    state=TLR; tl_reset=0 immediately; updateIR=updateDR=0; tdo_en=0; gate enables=0.
//    Strobes decode from TLR, so all are 0.
//  - Reset mid-shift: the gated clocks stop at once; the IR gets tl_reset=0 and reloads IDCODE.
//  - Reset released between edges: state leaves TLR only on a posedge with tms=0.
//    tl_reset rises on the negedge after that.
//  - tms is don't-care while reset=1.
// CONFIGURATION
//  TAP_STATE_OUT_EN defined: adds port tap_state out 4 (raw encoded state) for debug/observability. Reset value 4'hF.
//  Not defined: port absent; no other behaviour changes.
// STRUCTURE
//  - jtag_pkg holds tap_state_t (enum logic [3:0], encodings above) and the next-state function.
//    The function is shared with the bench model.
//  - One sub-module: jtag_clock_gate (latch ICG: tck, en -> gclk); instantiated twice, for tck_ir and tck_dr.
// TESTING
//  1. reset pulse mid-SHIR -> state=TLR, tl_reset=0 same cycle, tck_ir stops; tms=0 -> RTI, tl_reset=1 at next negedge.
//  2. From RTI, tms=1,1,0,0 -> CAPIR then SHIR: one tck_ir pulse with captureIR=1; tdo_en=1 from the SHIR negedge.
//  3. In SHIR, 4x tms=0 then tms=1 -> 5 tck_ir pulses in SHIR; EX1IR, tms=1 -> UPDIR; updateIR rises at that negedge, high 1 period.
//  4. Any state, tms=1 x5 -> TLR on 5th posedge; tl_reset=0 at following negedge; sweep all 16 start states.
//  5. DR path with pause: RTI tms=1,0,0,1,0,0,1,1 -> passes PAUDR, 2 holds, EX2DR, UPDDR.
//     Check no tck_dr pulses in PAUDR; updateDR one pulse; select=0 throughout.
//  6. Random 2000-cycle tms: state matches the jtag_pkg model every cycle; no tck_ir/tck_dr pulse shorter than half a tck period.

Source files
------------

// File: rtl/jtag_pkg.sv
// IEEE 1149.1 TAP state encodings and the next-state function of the 16-state graph.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package jtag_pkg;

    typedef enum logic [3:0] {
        EX2DR = 4'h0,
        EX1DR = 4'h1,
        SHDR  = 4'h2,
        PAUDR = 4'h3,
        SELIR = 4'h4,
        UPDDR = 4'h5,
        CAPDR = 4'h6,
        SELDR = 4'h7,
        EX2IR = 4'h8,
        EX1IR = 4'h9,
        SHIR  = 4'hA,
        PAUIR = 4'hB,
        RTI   = 4'hC,
        UPDIR = 4'hD,
        CAPIR = 4'hE,
        TLR   = 4'hF
    } tap_state_t;

    // Next TAP state for the current state and the tms value sampled on posedge tck.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TLR;
        case (s)
            TLR:     n = tms ? TLR   : RTI;
            RTI:     n = tms ? SELDR : RTI;
            SELDR:   n = tms ? SELIR : CAPDR;
            CAPDR:   n = tms ? EX1DR : SHDR;
            SHDR:    n = tms ? EX1DR : SHDR;
            EX1DR:   n = tms ? UPDDR : PAUDR;
            PAUDR:   n = tms ? EX2DR : PAUDR;
            EX2DR:   n = tms ? UPDDR : SHDR;
            UPDDR:   n = tms ? SELDR : RTI;
            SELIR:   n = tms ? TLR   : CAPIR;
            CAPIR:   n = tms ? EX1IR : SHIR;
            SHIR:    n = tms ? EX1IR : SHIR;
            EX1IR:   n = tms ? UPDIR : PAUIR;
            PAUIR:   n = tms ? EX2IR : PAUIR;
            EX2IR:   n = tms ? UPDIR : SHIR;
            UPDIR:   n = tms ? SELDR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_clock_gate.sv
// Latch-based clock gate: gclk_o = tck_i & enable latched during the low phase of tck_i.
// Latency: enable changes take effect from the next rising edge of tck_i.
// Backpressure: n/a. Ports: tck_i clock in, rst_i async active-high clear of the enable,
//   en_i gate enable, gclk_o gated clock out.
module jtag_clock_gate (
    input  logic tck_i,
    input  logic rst_i,
    input  logic en_i,
    output logic gclk_o
);

    logic en_q;

    // Transparent only while tck is low, so the enable cannot change during a high
    // phase and gclk_o never emits a truncated pulse. Reset kills the gate at once.
    always_latch begin
        if (rst_i) begin
            en_q <= 1'b0;
        end else if (!tck_i) begin
            en_q <= en_i;
        end
    end

    assign gclk_o = tck_i & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state register on posedge tck, strobes decoded from state,
// tl_reset/update/tdo_en registered on negedge tck, gated IR/DR shift clocks.
// Latency: strobes follow the state combinationally; negedge group lags state by half a tck.
// Backpressure: none; the TAP advances on every tck edge.
// Ports: tck, reset (async active-high), tms in; tl_reset (active-low), captureIR, shiftIR,
//   updateIR, captureDR, shiftDR, updateDR, tck_ir, tck_dr, select, tdo_en out.
// Optional: define TAP_STATE_OUT_EN to expose the raw encoded state on tap_state (reset 4'hF).
module tap_controller
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       reset,
    input  logic       tms,
    output logic       tl_reset,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       updateIR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       tck_ir,
    output logic       tck_dr,
    output logic       select,
    output logic       tdo_en
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0] tap_state
`endif
);

    tap_state_t state_q, state_d;
    logic       tl_reset_q, update_ir_q, update_dr_q, tdo_en_q;
    logic       ir_gate_en, dr_gate_en;

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = tap_next(state_q, tms);
        captureIR = 1'b0;
        shiftIR   = 1'b0;
        captureDR = 1'b0;
        shiftDR   = 1'b0;
        select    = 1'b0;
        case (state_q)
            CAPIR:   captureIR = 1'b1;
            SHIR:    shiftIR   = 1'b1;
            CAPDR:   captureDR = 1'b1;
            SHDR:    shiftDR   = 1'b1;
            default: ;
        endcase
        case (state_q)
            SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR: select = 1'b1;
            default: select = 1'b0;
        endcase
    end

    // Negedge group: settles half a cycle after each state change, so downstream
    // registers clocked on posedge see stable update/reset levels.
    always_ff @(negedge tck or posedge reset) begin
        if (reset) begin
            tl_reset_q  <= 1'b0;
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
            tdo_en_q    <= 1'b0;
        end else begin
            tl_reset_q  <= (state_q != TLR);
            update_ir_q <= (state_q == UPDIR);
            update_dr_q <= (state_q == UPDDR);
            tdo_en_q    <= (state_q == SHIR) || (state_q == SHDR);
        end
    end

    assign tl_reset = tl_reset_q;
    assign updateIR = update_ir_q;
    assign updateDR = update_dr_q;
    assign tdo_en   = tdo_en_q;

    // The gate opens during the low phase of a capture/shift state, so the gated
    // clock rises exactly on the posedge that consumes that state.
    assign ir_gate_en = (state_q == CAPIR) || (state_q == SHIR);
    assign dr_gate_en = (state_q == CAPDR) || (state_q == SHDR);

    jtag_clock_gate u_gate_ir (
        .tck_i  (tck),
        .rst_i  (reset),
        .en_i   (ir_gate_en),
        .gclk_o (tck_ir)
    );

    jtag_clock_gate u_gate_dr (
        .tck_i  (tck),
        .rst_i  (reset),
        .en_i   (dr_gate_en),
        .gclk_o (tck_dr)
    );

`ifdef TAP_STATE_OUT_EN
    assign tap_state = state_q;
`endif

endmodule

// File: tb/tb_tap_controller.sv
module tb_tap_controller;

    logic tck = 1'b0;
    logic reset, tms;
    logic tl_reset, captureIR, shiftIR, updateIR, captureDR, shiftDR, updateDR;
    logic tck_ir, tck_dr, select, tdo_en;
`ifdef TAP_STATE_OUT_EN
    logic [3:0] tap_state;
`endif

    always #5 tck = ~tck;

    tap_controller dut (
        .tck       (tck),
        .reset     (reset),
        .tms       (tms),
        .tl_reset  (tl_reset),
        .captureIR (captureIR),
        .shiftIR   (shiftIR),
        .updateIR  (updateIR),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .updateDR  (updateDR),
        .tck_ir    (tck_ir),
        .tck_dr    (tck_dr),
        .select    (select),
        .tdo_en    (tdo_en)
`ifdef TAP_STATE_OUT_EN
        ,
        .tap_state (tap_state)
`endif
    );

    // Reference model: the 1149.1 graph as a transition table indexed by state encoding.
    localparam int S_EX2DR = 0, S_EX1DR = 1, S_SHDR = 2, S_PAUDR = 3, S_SELIR = 4,
                   S_UPDDR = 5, S_CAPDR = 6, S_SELDR = 7, S_EX2IR = 8, S_EX1IR = 9,
                   S_SHIR = 10, S_PAUIR = 11, S_RTI = 12, S_UPDIR = 13, S_CAPIR = 14,
                   S_TLR = 15;
    int nx0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nx1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int n_cmp = 0;
    int n_bad = 0;
    int cur = S_TLR;
    int exp_q[$];
    int exp_ir = 0, exp_dr = 0;
    int ir_cnt = 0, dr_cnt = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic bit is_ir_side(input int s);
        return (s == S_SELIR) || (s == S_CAPIR) || (s == S_SHIR) || (s == S_EX1IR) ||
               (s == S_PAUIR) || (s == S_EX2IR) || (s == S_UPDIR);
    endfunction

    // Stimulus: one tms value per posedge; the predicted next state goes to the scoreboard.
    task automatic step(input bit t);
        @(negedge tck);
        #1;
        tms = t;
        if (cur == S_CAPIR || cur == S_SHIR) exp_ir++;
        if (cur == S_CAPDR || cur == S_SHDR) exp_dr++;
        cur = t ? nx1[cur] : nx0[cur];
        exp_q.push_back(cur);
    endtask

    task automatic goto_state(input int target);
        int n = 0;
        while (cur != target && n < 1000) begin
            step(1'($urandom_range(0, 1)));
            n++;
        end
        chk("goto_state_reached", cur, target);
    endtask

    task automatic check_pulses(input string tag);
        @(posedge tck);
        #2;
        chk({tag, "_tck_ir_pulses"}, ir_cnt, exp_ir);
        chk({tag, "_tck_dr_pulses"}, dr_cnt, exp_dr);
    endtask

    // Async reset pulse while tck is low; tms held 1 afterwards so TLR is kept.
    task automatic reset_pulse();
        @(negedge tck);
        #2;
        reset = 1'b1;
        tms   = 1'($urandom_range(0, 1));
        #1;
        chk("rst_tl_reset", tl_reset, 0);
        chk("rst_tck_ir", tck_ir, 0);
        chk("rst_tdo_en", tdo_en, 0);
        chk("rst_shiftIR", shiftIR, 0);
        tms   = 1'b1;
        #1;
        reset = 1'b0;
        cur   = S_TLR;
    endtask

    always @(posedge tck_ir) ir_cnt++;
    always @(posedge tck_dr) dr_cnt++;

    // Gated clock pulses must fall in a capture/shift state and last a full half period.
    always begin
        time t0;
        @(posedge tck_ir);
        t0 = $time;
        chk("tck_ir_in_window", int'(captureIR | shiftIR), 1);
        @(negedge tck_ir);
        chk("tck_ir_width_ok", int'(($time - t0) >= 5), 1);
    end

    always begin
        time t0;
        @(posedge tck_dr);
        t0 = $time;
        chk("tck_dr_in_window", int'(captureDR | shiftDR), 1);
        @(negedge tck_dr);
        chk("tck_dr_width_ok", int'(($time - t0) >= 5), 1);
    end

    // Monitor: after each posedge pop the expected state, check decoded strobes, then
    // check the negedge group half a cycle later.
    always begin
        int s;
        @(posedge tck);
        #1;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
`ifdef TAP_STATE_OUT_EN
            chk("tap_state", int'(tap_state), s);
`endif
            chk("captureIR", captureIR, int'(s == S_CAPIR));
            chk("shiftIR", shiftIR, int'(s == S_SHIR));
            chk("captureDR", captureDR, int'(s == S_CAPDR));
            chk("shiftDR", shiftDR, int'(s == S_SHDR));
            chk("select", select, int'(is_ir_side(s)));
            @(negedge tck);
            #1;
            chk("tl_reset", tl_reset, int'(s != S_TLR));
            chk("updateIR", updateIR, int'(s == S_UPDIR));
            chk("updateDR", updateDR, int'(s == S_UPDDR));
            chk("tdo_en", tdo_en, int'(s == S_SHIR || s == S_SHDR));
        end
    end

    initial begin
        reset = 1'b1;
        tms   = 1'($urandom_range(0, 1));
        #2;
        chk("init_tl_reset", tl_reset, 0);
        chk("init_updateIR", updateIR, 0);
        chk("init_updateDR", updateDR, 0);
        chk("init_tdo_en", tdo_en, 0);
        chk("init_select", select, 0);
        chk("init_captureIR", captureIR, 0);
        chk("init_tck_ir", tck_ir, 0);
        chk("init_tck_dr", tck_dr, 0);
`ifdef TAP_STATE_OUT_EN
        chk("init_tap_state", int'(tap_state), 15);
`endif
        tms = 1'b1;
        #10;
        reset = 1'b0;

        // IR scan: capture, five shifts, exit, update, back to idle.
        step(0);
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 4; i++) step(0);
        step(1); step(1); step(0);
        check_pulses("ir_scan");

        // Reset in the middle of SHIFT_IR, then leave TLR with tms=0.
        step(1); step(1); step(0); step(0); step(0);
        reset_pulse();
        step(0);
        check_pulses("mid_shift_reset");

        // DR scan through PAUSE_DR.
        step(1); step(0); step(0); step(1); step(0); step(0); step(1); step(1);
        step(0);
        check_pulses("dr_pause");

        // Five tms=1 edges reach TLR from every start state.
        for (int s = 0; s < 16; s++) begin
            goto_state(s);
            for (int k = 0; k < 5; k++) step(1);
        end
        check_pulses("tlr_sweep");

        // Random tms walk.
        for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)));
        check_pulses("random");

        repeat (3) @(negedge tck);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
